// File: rtl/data_demux_1x2_if.sv
// Handshake bundle for the 1-to-2 demultiplexer: one input stream and two
// independent output streams, each with valid/ready flow control.
interface data_demux_1x2_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sel;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    // Producer / consumer side (drives the input stream, takes the outputs)
    modport master (
        output in_data, in_valid, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    // Demultiplexer side
    modport slave (
        input  in_data, in_valid, in_sel, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );
endinterface

// File: rtl/data_demux_1x2.sv
// 1-to-2 data demultiplexer. Each output port owns a 2-entry FIFO so a stalled
// consumer on one port never blocks traffic steered to the other port.
// Per-port 16-bit counters tally accepted words and can be cleared together.
module data_demux_1x2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    data_demux_1x2_if.slave    bus,
    input  logic               cnt_clr,
    output logic [15:0]        cnt0,
    output logic [15:0]        cnt1
);

    logic [1:0]       out_ready;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       valid;
    logic [1:0]       full;
    logic [WIDTH-1:0] head    [2];
    logic [15:0]      cnt_all [2];
    logic             in_ready_int;
    logic             xfer;

    assign out_ready = {bus.out1_ready, bus.out0_ready};

    // in_ready depends only on registered occupancy, never on downstream ready,
    // so there is no combinational path from out*_ready to in_ready.
    assign in_ready_int = bus.in_sel ? ~full[1] : ~full[0];
    assign xfer         = bus.in_valid & in_ready_int;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [WIDTH-1:0] mem_q [2];
            logic [WIDTH-1:0] mem_d [2];
            logic             rd_q, rd_d;
            logic             wr_q, wr_d;
            logic [1:0]       occ_q, occ_d;
            logic [15:0]      cnt_q, cnt_d;

            assign push[gi]    = xfer & (bus.in_sel == (gi == 1));
            assign pop[gi]     = valid[gi] & out_ready[gi];
            assign valid[gi]   = (occ_q != 2'd0);
            assign full[gi]    = (occ_q == 2'd2);
            assign head[gi]    = mem_q[rd_q];
            assign cnt_all[gi] = cnt_q;

            // FIFO next state: write at wr pointer, advance head on pop.
            // Push at occupancy 0 cannot coincide with a pop, and push at
            // occupancy 2 is blocked by in_ready, so occupancy stays in 0..2.
            always_comb begin
                mem_d = mem_q;
                rd_d  = rd_q;
                wr_d  = wr_q;
                occ_d = occ_q;
                if (push[gi]) begin
                    mem_d[wr_q] = bus.in_data;
                    wr_d        = ~wr_q;
                end
                if (pop[gi]) begin
                    rd_d = ~rd_q;
                end
                occ_d = occ_q + {1'b0, push[gi]} - {1'b0, pop[gi]};
            end

            // Transfer counter: clear wins over a coincident increment.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = 16'd0;
                end else if (push[gi]) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // FIFO and counter registers; reset empties the queue and zeroes
            // storage so the data outputs read 0 while reset is held.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[0] <= '0;
                    mem_q[1] <= '0;
                    rd_q     <= 1'b0;
                    wr_q     <= 1'b0;
                    occ_q    <= 2'd0;
                    cnt_q    <= 16'd0;
                end else begin
                    mem_q[0] <= mem_d[0];
                    mem_q[1] <= mem_d[1];
                    rd_q     <= rd_d;
                    wr_q     <= wr_d;
                    occ_q    <= occ_d;
                    cnt_q    <= cnt_d;
                end
            end
        end
    endgenerate

    assign bus.in_ready   = in_ready_int;
    assign bus.out0_data  = head[0];
    assign bus.out0_valid = valid[0];
    assign bus.out1_data  = head[1];
    assign bus.out1_valid = valid[1];
    assign cnt0           = cnt_all[0];
    assign cnt1           = cnt_all[1];

endmodule

// File: tb/tb_data_demux_1x2.sv
// Scoreboard bench for data_demux_1x2: words are queued per port when driven
// and checked against the DUT head as it is offered and consumed.
module tb_data_demux_1x2;

    logic        clk;
    logic        rst_n;
    logic        cnt_clr;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    data_demux_1x2_if #(.WIDTH(32)) bus ();

    data_demux_1x2 #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks  = 0;
    int          errors  = 0;
    bit          verbose = 1'b1;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [15:0] m_cnt0  = 16'd0;
    logic [15:0] m_cnt1  = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit sel, input logic [31:0] d,
                         input bit r0, input bit r1, input bit clr);
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        cnt_clr        = clr;
    endtask

    // Check outputs against the model, predict this edge, then clock it.
    task automatic step();
        bit exp_rdy, xfer, p0, p1;
        #1;
        exp_rdy = bus.in_sel ? (q1.size() < 2) : (q0.size() < 2);
        check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check_val("out0_valid", {31'd0, bus.out0_valid}, {31'd0, q0.size() > 0});
        check_val("out1_valid", {31'd0, bus.out1_valid}, {31'd0, q1.size() > 0});
        if (q0.size() > 0) check_val("out0_data", bus.out0_data, q0[0]);
        if (q1.size() > 0) check_val("out1_data", bus.out1_data, q1[0]);
        check_val("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
        check_val("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
        xfer = bus.in_valid && exp_rdy;
        p0   = bus.out0_ready && (q0.size() > 0);
        p1   = bus.out1_ready && (q1.size() > 0);
        if (p0) begin
            if (verbose) $display("pop  port0 data=%h", q0[0]);
            void'(q0.pop_front());
        end
        if (p1) begin
            if (verbose) $display("pop  port1 data=%h", q1[0]);
            void'(q1.pop_front());
        end
        if (xfer) begin
            if (verbose) $display("push port%0d data=%h", bus.in_sel, bus.in_data);
            if (bus.in_sel) q1.push_back(bus.in_data);
            else            q0.push_back(bus.in_data);
        end
        if (cnt_clr) begin
            m_cnt0 = 16'd0;
            m_cnt1 = 16'd0;
        end else if (xfer) begin
            if (bus.in_sel) m_cnt1 = m_cnt1 + 16'd1;
            else            m_cnt0 = m_cnt0 + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0);
        #2;
        // Reset state, independent of clock
        check_val("rst_out0_valid", {31'd0, bus.out0_valid}, 32'd0);
        check_val("rst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        check_val("rst_out0_data", bus.out0_data, 32'd0);
        check_val("rst_out1_data", bus.out1_data, 32'd0);
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("rst_cnt0", {16'd0, cnt0}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single push to port 0, visible the next cycle
        drive(1, 0, 32'h1111_1111, 0, 0, 0); step();
        drive(0, 0, 32'h0, 0, 0, 0);          step();
        check_val("first_cnt0", {16'd0, cnt0}, 32'd1);
        drive(0, 0, 32'h0, 1, 0, 0);          step();

        // Fill port 1 with consumer stalled; C held while full
        drive(1, 1, 32'hA, 0, 0, 0); step();
        drive(1, 1, 32'hB, 0, 0, 0); step();
        drive(1, 1, 32'hC, 0, 0, 0); step();
        check_val("full_blocks", {31'd0, bus.in_ready}, 32'd0);
        drive(1, 1, 32'hC, 0, 0, 0); step();
        // Full port 1 does not block port 0
        drive(1, 0, 32'h77, 0, 0, 0); step();
        // Drain port 1 while C keeps being offered
        drive(1, 1, 32'hC, 1, 1, 0); step();
        drive(1, 1, 32'hC, 1, 1, 0); step();
        drive(0, 1, 32'h0, 1, 1, 0); step();
        drive(0, 1, 32'h0, 1, 1, 0); step();

        // Simultaneous push/pop at occupancy 1 on port 0
        drive(1, 0, 32'h5, 0, 0, 0); step();
        drive(1, 0, 32'h6, 1, 0, 0); step();
        check_val("pp_data", bus.out0_data, 32'h6);
        drive(0, 0, 32'h0, 1, 0, 0); step();

        // Push to one port while popping the other
        drive(1, 1, 32'hD1, 0, 0, 0); step();
        drive(1, 0, 32'hD0, 0, 1, 0); step();
        drive(0, 0, 32'h0, 1, 1, 0);  step();

        // Counter wrap on port 1
        drive(0, 0, 32'h0, 0, 0, 1); step();
        verbose = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(1, 1, 32'(i), 0, 1, 0); step();
        end
        verbose = 1'b1;
        check_val("cnt1_max", {16'd0, cnt1}, 32'h0000_FFFF);
        drive(1, 1, 32'hF00D, 0, 1, 0); step();
        check_val("cnt1_wrap", {16'd0, cnt1}, 32'd0);
        drive(0, 0, 32'h0, 0, 1, 0);    step();
        // Clear coincident with a port-0 transfer: word kept, not counted
        drive(1, 0, 32'hCAFE, 0, 0, 1); step();
        drive(0, 0, 32'h0, 0, 0, 0);    step();
        check_val("clr_cnt0", {16'd0, cnt0}, 32'd0);
        check_val("clr_word", bus.out0_data, 32'hCAFE);

        // Fill both ports, then reset between edges
        drive(1, 0, 32'hE0, 0, 0, 0); step();
        drive(1, 1, 32'hE1, 0, 0, 0); step();
        drive(1, 1, 32'hE2, 0, 0, 0); step();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_out0_valid", {31'd0, bus.out0_valid}, 32'd0);
        check_val("mrst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        check_val("mrst_in_ready1", {31'd0, bus.in_ready}, 32'd1);
        check_val("mrst_out1_data", bus.out1_data, 32'd0);
        check_val("mrst_cnt1", {16'd0, cnt1}, 32'd0);
        bus.in_sel = 1'b0;
        #1;
        check_val("mrst_in_ready0", {31'd0, bus.in_ready}, 32'd1);
        q0.delete();
        q1.delete();
        m_cnt0 = 16'd0;
        m_cnt1 = 16'd0;
        rst_n = 1'b1;

        // First edge after reset release accepts a transfer
        drive(1, 1, 32'h1234_5678, 0, 0, 0); step();
        drive(0, 0, 32'h0, 0, 1, 0);          step();
        drive(0, 0, 32'h0, 0, 0, 0);          step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
